// File: rtl/tx_arbiter_pkg.sv
// rtl/tx_arbiter_pkg.sv - shared defaults and FSM encoding for the tx arbiter
package tx_arbiter_pkg;

    // Default number of byte-stream requesters sharing the avr_interface transmitter.
    localparam int NUM_REQ_DEF   = 4;

    // Default number of bytes a requester may send before it is forced off the channel.
    localparam int MAX_FRAME_DEF = 64;

    // Arbiter FSM. GAP is the one-cycle hold-off after every strobe that lets tx_busy rise.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tx_arbiter_if.sv
// rtl/tx_arbiter_if.sv - requester and avr_interface signals of the tx arbiter
interface tx_arbiter_if
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);

    // Requester side.
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;

    // avr_interface transmitter side.
    logic [7:0]           tx_data;
    logic                 new_tx_data;
    logic                 tx_busy;

    // Status.
    logic                 overflow;

    // The arbiter itself.
    modport slave (
        input  req,
        input  req_data,
        input  req_last,
        input  tx_busy,
        output req_ack,
        output grant,
        output tx_data,
        output new_tx_data,
        output overflow
    );

    // Requesters plus transmitter, as seen from outside the arbiter.
    modport master (
        output req,
        output req_data,
        output req_last,
        output tx_busy,
        input  req_ack,
        input  grant,
        input  tx_data,
        input  new_tx_data,
        input  overflow
    );

endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// rtl/tx_arbiter_rr_pick.sv - combinational round-robin winner selection
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_valid
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // Scan upward from the pointer, wrapping, and take the first pending request.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin byte-stream arbiter in front of avr_interface tx
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int MAX_FRAME = MAX_FRAME_DEF
) (
    input  logic        clk,
    input  logic        rst,
    tx_arbiter_if.slave bus
);

    localparam int                PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                CNT_W    = $clog2(MAX_FRAME + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_FRAME);

    // Registered state and outputs.
    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]     r_byte_cnt;
    logic                 r_last_q;
    logic [7:0]           r_tx_data;
    logic                 r_new_tx_data;
    logic [NUM_REQ-1:0]   r_req_ack;
    logic                 r_overflow;

    // Next-state values.
    arb_state_t           w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]     w_owner_nxt;
    logic [PTR_W-1:0]     w_rr_ptr_nxt;
    logic [CNT_W-1:0]     w_byte_cnt_nxt;
    logic                 w_last_q_nxt;
    logic [7:0]           w_tx_data_nxt;
    logic                 w_new_tx_data_nxt;
    logic [NUM_REQ-1:0]   w_req_ack_nxt;
    logic                 w_overflow_nxt;

    // Owner view and round-robin helpers.
    logic [NUM_REQ-1:0]   w_win;
    logic                 w_win_valid;
    logic [PTR_W-1:0]     w_win_idx;
    logic                 w_own_req;
    logic                 w_own_last;
    logic [7:0]           w_own_data;
    logic [PTR_W-1:0]     w_rel_ptr;
    logic                 w_at_max;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_win),
        .o_valid  (w_win_valid)
    );

    // Encode the one-hot winner into the owner index kept while the frame is granted.
    always_comb begin
        w_win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win[k]) begin
                w_win_idx = PTR_W'(k);
            end
        end
    end

    // Select the current owner's byte from the packed requester data bus.
    always_comb begin
        w_own_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == PTR_W'(k)) begin
                w_own_data = bus.req_data[8*k +: 8];
            end
        end
    end

    assign w_own_req  = bus.req[r_owner];
    assign w_own_last = bus.req_last[r_owner];
    assign w_rel_ptr  = (r_owner == LAST_PTR) ? '0 : r_owner + PTR_W'(1);
    assign w_at_max   = (r_byte_cnt == CNT_MAX);

    // Next-state and output decode; strobes and acks default low so they only pulse.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_owner_nxt       = r_owner;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_last_q_nxt      = r_last_q;
        w_tx_data_nxt     = r_tx_data;
        w_new_tx_data_nxt = 1'b0;
        w_req_ack_nxt     = '0;
        w_overflow_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_grant_nxt    = w_win;
                    w_owner_nxt    = w_win_idx;
                    w_byte_cnt_nxt = '0;
                    w_last_q_nxt   = 1'b0;
                    w_state_nxt    = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (!w_own_req) begin
                    // Owner walked away mid-frame: hand the channel on.
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_rel_ptr;
                    w_state_nxt  = ST_IDLE;
                end else if (!bus.tx_busy) begin
                    w_tx_data_nxt     = w_own_data;
                    w_new_tx_data_nxt = 1'b1;
                    w_req_ack_nxt     = r_grant;
                    w_last_q_nxt      = w_own_last;
                    w_byte_cnt_nxt    = w_at_max ? r_byte_cnt : r_byte_cnt + CNT_W'(1);
                    w_state_nxt       = ST_GAP;
                end
            end

            ST_GAP: begin
                // req_data is not sampled here; the requester is still updating it.
                if (r_last_q || w_at_max) begin
                    w_grant_nxt    = '0;
                    w_rr_ptr_nxt   = w_rel_ptr;
                    w_overflow_nxt = !r_last_q && w_at_max;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end

            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that silently aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_byte_cnt    <= '0;
            r_last_q      <= 1'b0;
            r_tx_data     <= 8'h00;
            r_new_tx_data <= 1'b0;
            r_req_ack     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_owner       <= w_owner_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_last_q      <= w_last_q_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_new_tx_data <= w_new_tx_data_nxt;
            r_req_ack     <= w_req_ack_nxt;
            r_overflow    <= w_overflow_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.req_ack     = r_req_ack;
    assign bus.tx_data     = r_tx_data;
    assign bus.new_tx_data = r_new_tx_data;
    assign bus.overflow    = r_overflow;

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  NUM_REQ    4    number of byte-stream requesters
  MAX_FRAME  64   maximum bytes per granted frame before forced release
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk          input   1          system clock; single clock domain
  rst          input   1          synchronous, active-high reset
  req          input   NUM_REQ    requester i has a byte pending on req_data slice i
  req_data     input   8*NUM_REQ  byte of requester i on bits [8i+7:8i]
  req_last     input   NUM_REQ    pending byte of requester i ends its frame
  req_ack      output  NUM_REQ    one-cycle pulse: byte of requester i accepted
  grant        output  NUM_REQ    one-hot owner of the tx channel; all zero when free
  tx_data      output  8          byte to avr_interface
  new_tx_data  output  1          one-cycle strobe to avr_interface
  tx_busy      input   1          avr_interface transmitter busy
  overflow     output  1          one-cycle pulse on forced release at MAX_FRAME

Function
REQ-003 The FSM SHALL have states IDLE, GRANT and GAP, as listed below.
REQ-004 IDLE: if any req bit is high, the block SHALL pick a round-robin winner from rr_ptr upward (wrapping), set grant one-hot to it on the next edge, clear byte_cnt and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-005 GRANT, owner g: if req[g]=1 and tx_busy=0, then on the next edge it SHALL register tx_data=req_data[g], new_tx_data=1, req_ack[g]=1, latch last_q=req_last[g], increment byte_cnt and go to GAP.
REQ-006 GRANT with req[g]=0 SHALL release: grant cleared, rr_ptr=(g+1) mod NUM_REQ, go to IDLE, no strobe.
REQ-007 GRANT with req[g]=1 and tx_busy=1 SHALL hold state and grant, with no strobe.
REQ-008 GAP SHALL last exactly one cycle, covering the tx_busy assertion latency.
  - new_tx_data and req_ack deassert in GAP.
  - If last_q=1 or byte_cnt=MAX_FRAME: release as in REQ-006, with rr_ptr=(g+1) mod NUM_REQ.
  - Otherwise: return to GRANT.
REQ-009 Release by byte_cnt=MAX_FRAME with last_q=0 SHALL pulse overflow for one cycle, coincident with grant clearing.
REQ-010 Minimum strobe spacing SHALL be 2 cycles; new_tx_data SHALL never assert while tx_busy was high in the deciding cycle.
REQ-011 The requester SHALL present its next byte in the cycle after req_ack; the arbiter SHALL NOT sample req_data[g] in GAP.
REQ-012 Requests from non-owners SHALL be ignored until release; a requester SHALL NOT be preempted mid-frame.
REQ-013 Simultaneous requests in IDLE SHALL be resolved purely by rr_ptr; a releasing owner becomes lowest priority.
REQ-014 byte_cnt SHALL be clog2(MAX_FRAME+1) bits wide and SHALL NOT wrap; req_ack and grant bits SHALL be one-hot or zero.
REQ-015 All outputs SHALL be registered; decision-to-strobe latency is 1 cycle.

Reset
REQ-016 With rst=1 at a clock edge, the block SHALL enter IDLE with grant=0, req_ack=0, new_tx_data=0, tx_data=8'h00, overflow=0, rr_ptr=0, byte_cnt=0 and last_q=0.
REQ-017 Reset mid-frame SHALL abort silently: no strobe, ack or overflow is generated in the reset cycle or the cycle after.

Structure
REQ-018 The state encodings (2 bits), NUM_REQ and MAX_FRAME defaults SHALL reside in the shared avionics package/header.
REQ-019 Round-robin selection SHALL be a sub-module rr_pick: inputs req and rr_ptr, outputs one-hot winner and valid; combinational.
REQ-020 The block SHALL sit between requesters (debugging, flags telemetry) and avr_interface tx_data/new_tx_data/tx_busy.

Verification
REQ-021 Single frame: req0 sends 8'hA5, 8'h5A (last), tx_busy=0 -> two strobes 2 cycles apart, tx_data A5 then 5A, grant0 clears in the GAP after the 5A strobe, rr_ptr=1.
REQ-022 Contention: req0..req3 high from reset, each sending 1-byte frames -> grants in order 0,1,2,3,0; no overlapping grants.
REQ-023 Backpressure: tx_busy held high for 10 cycles after the first strobe -> no strobe during busy; the second byte is strobed 1 cycle after tx_busy falls.
REQ-024 Overflow: req2 streams with req_last=0 -> exactly 64 strobes, then overflow pulse, grant2 released, rr_ptr=3.
REQ-025 Abandon and reset: req1 drops after 3 bytes -> release with no overflow; rst asserted mid-frame -> all outputs zero next cycle, IDLE, rr_ptr=0.
